// File: rtl/mips_state_dump.sv
// ---------------------------------------------------------------------------
// mips_state_dump
//
// Post-run readout engine for the pipe_MIPS32 core. Once the core halts (or a
// host requests it with start) it reads the first NUM_REGS general registers
// and then MEM_COUNT data-memory words starting at MEM_BASE. Each word is
// streamed out on a valid/ready port together with a tag and an index.
//
// Ports
//   clk1        single clock, everything on the rising edge
//   reset       asynchronous, active-high reset
//   halted      core HALTED flag; its rising edge triggers a dump
//   start       one-cycle dump request, honoured in IDLE or DONE only
//   reg_addr    register-file read address (held between reads)
//   reg_rd      register read strobe, data returns on reg_rdata next cycle
//   reg_rdata   register read data
//   mem_addr    data-memory read address (held between reads)
//   mem_rd      memory read strobe, data returns on mem_rdata next cycle
//   mem_rdata   memory read data
//   out_valid   stream beat valid
//   out_ready   stream sink accepts the beat
//   out_data    word read from the core
//   out_tag     0 = register word, 1 = memory word
//   out_index   register number, or word offset from MEM_BASE
//   busy        a dump is in progress
//   done        the full dump has been delivered
// ---------------------------------------------------------------------------
module mips_state_dump #(
    parameter int NUM_REGS  = 6,
    parameter int MEM_AW    = 10,
    parameter int MEM_BASE  = 120,
    parameter int MEM_COUNT = 2
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              halted,
    input  logic              start,
    output logic [4:0]        reg_addr,
    output logic              reg_rd,
    input  logic [31:0]       reg_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_tag,
    output logic [7:0]        out_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic              PHASE_REG = 1'b0;
    localparam logic              PHASE_MEM = 1'b1;
    localparam logic [7:0]        LAST_REG  = 8'(NUM_REGS - 1);
    localparam logic [7:0]        LAST_MEM  = 8'(MEM_COUNT - 1);
    localparam bit                HAS_MEM   = (MEM_COUNT > 0);
    localparam logic [MEM_AW-1:0] BASE_ADDR = MEM_AW'(MEM_BASE);

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [7:0]         idx_q, idx_d;
    logic               halted_q;
    logic               armed_q;
    logic [4:0]         reg_addr_q;
    logic [MEM_AW-1:0]  mem_addr_q;
    logic [31:0]        out_data_q;
    logic               out_tag_q;
    logic [7:0]         out_index_q;

    logic               haltRise;
    logic               haltFall;
    logic               trigger;
    logic [MEM_AW-1:0]  memAddrCalc;

    // armed_q masks edge detection for the first cycle after reset. Without
    // it, a core that is still halted when reset is released would look like
    // a fresh halt (halted_q restarts at 0) and launch an unwanted dump.
    assign haltRise = halted & ~halted_q & armed_q;
    assign haltFall = ~halted & halted_q;
    assign trigger  = haltRise | start;

    // Memory address arithmetic deliberately wraps modulo 2^MEM_AW.
    assign memAddrCalc = BASE_ADDR + MEM_AW'(idx_q);

    // State register plus the datapath registers that move with it. The
    // captured beat is only loaded in CAPTURE, which keeps it stable for the
    // whole of SEND regardless of out_ready.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PHASE_REG;
            idx_q       <= 8'd0;
            halted_q    <= 1'b0;
            armed_q     <= 1'b0;
            reg_addr_q  <= 5'd0;
            mem_addr_q  <= '0;
            out_data_q  <= 32'd0;
            out_tag_q   <= 1'b0;
            out_index_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            halted_q   <= halted;
            armed_q    <= 1'b1;
            reg_addr_q <= reg_addr;
            mem_addr_q <= mem_addr;
            if (state_q == S_CAPTURE) begin
                out_data_q  <= (phase_q == PHASE_MEM) ? mem_rdata : reg_rdata;
                out_tag_q   <= phase_q;
                out_index_q <= idx_q;
            end
        end
    end

    // Next-state logic. Triggers only matter in IDLE and DONE, so a start
    // or halt edge during a dump is simply not looked at. A trigger in DONE
    // wins over a falling halted in the same cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (trigger) begin
                    state_d = S_ISSUE;
                    phase_d = PHASE_REG;
                    idx_d   = 8'd0;
                end else if (state_q == S_DONE && haltFall) begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (phase_q == PHASE_REG) begin
                        if (idx_q == LAST_REG) begin
                            if (HAS_MEM) begin
                                state_d = S_ISSUE;
                                phase_d = PHASE_MEM;
                                idx_d   = 8'd0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            state_d = S_ISSUE;
                            idx_d   = idx_q + 8'd1;
                        end
                    end else begin
                        if (idx_q == LAST_MEM) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ISSUE;
                            idx_d   = idx_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so out_ready never
    // reaches an output combinationally. Read addresses follow the index
    // while their strobe is up and otherwise hold the last issued value.
    always_comb begin
        reg_rd    = (state_q == S_ISSUE) && (phase_q == PHASE_REG);
        mem_rd    = (state_q == S_ISSUE) && (phase_q == PHASE_MEM);
        reg_addr  = reg_rd ? idx_q[4:0] : reg_addr_q;
        mem_addr  = mem_rd ? memAddrCalc : mem_addr_q;
        out_valid = (state_q == S_SEND);
        busy      = (state_q == S_ISSUE) || (state_q == S_CAPTURE) ||
                    (state_q == S_SEND);
        done      = (state_q == S_DONE);
        out_data  = out_data_q;
        out_tag   = out_tag_q;
        out_index = out_index_q;
    end

endmodule

// File: tb/tb_mips_state_dump.sv
// Testbench for mips_state_dump. Three instances share clock and reset:
//   A: default parameters (6 registers, 2 memory words at 120)
//   B: NUM_REGS=1, MEM_AW=7, MEM_BASE=127, MEM_COUNT=2 (address wrap)
//   C: MEM_COUNT=0 (no memory phase)
module tb_mips_state_dump;

   // Hand-computed beat sequences
   localparam logic [31:0] EXP_A [8] = '{32'd0, 32'd120, 32'd85, 32'd3,
                                         32'd4, 32'd130, 32'd85, 32'd130};
   localparam logic [31:0] EXP_B [3] = '{32'd0, 32'h0000_00AA, 32'h0000_00BB};

   logic clk1 = 1'b0;
   logic reset;
   logic haltedS [3];
   logic startS [3];
   logic outReady;

   logic [4:0]  regAddrA, regAddrB, regAddrC;
   logic        regRdA, regRdB, regRdC;
   logic [31:0] regRdataA, regRdataB, regRdataC;
   logic [9:0]  memAddrA, memAddrC;
   logic [6:0]  memAddrB;
   logic        memRdA, memRdB, memRdC;
   logic [31:0] memRdataA, memRdataB, memRdataC;
   logic        outValidA, outValidB, outValidC;
   logic [31:0] outDataA, outDataB, outDataC;
   logic        outTagA, outTagB, outTagC;
   logic [7:0]  outIndexA, outIndexB, outIndexC;
   logic        busyA, busyB, busyC;
   logic        doneA, doneB, doneC;

   logic [31:0] regFile [32];
   logic [31:0] memA [1024];
   logic [31:0] memB [128];
   int          memAddrLogB [$];
   int          memRdCountC;

   int sel;
   logic        curValid, curTag, curBusy, curDone, curRegRd;
   logic [31:0] curData;
   logic [7:0]  curIndex;

   int testCount = 0;
   int failCount = 0;

   // Clock generation
   always #5 clk1 = ~clk1;

   mips_state_dump dutA (
      .clk1(clk1), .reset(reset), .halted(haltedS[0]), .start(startS[0]),
      .reg_addr(regAddrA), .reg_rd(regRdA), .reg_rdata(regRdataA),
      .mem_addr(memAddrA), .mem_rd(memRdA), .mem_rdata(memRdataA),
      .out_valid(outValidA), .out_ready(outReady), .out_data(outDataA),
      .out_tag(outTagA), .out_index(outIndexA), .busy(busyA), .done(doneA)
   );

   mips_state_dump #(.NUM_REGS(1), .MEM_AW(7), .MEM_BASE(127), .MEM_COUNT(2)) dutB (
      .clk1(clk1), .reset(reset), .halted(haltedS[1]), .start(startS[1]),
      .reg_addr(regAddrB), .reg_rd(regRdB), .reg_rdata(regRdataB),
      .mem_addr(memAddrB), .mem_rd(memRdB), .mem_rdata(memRdataB),
      .out_valid(outValidB), .out_ready(outReady), .out_data(outDataB),
      .out_tag(outTagB), .out_index(outIndexB), .busy(busyB), .done(doneB)
   );

   mips_state_dump #(.MEM_COUNT(0)) dutC (
      .clk1(clk1), .reset(reset), .halted(haltedS[2]), .start(startS[2]),
      .reg_addr(regAddrC), .reg_rd(regRdC), .reg_rdata(regRdataC),
      .mem_addr(memAddrC), .mem_rd(memRdC), .mem_rdata(memRdataC),
      .out_valid(outValidC), .out_ready(outReady), .out_data(outDataC),
      .out_tag(outTagC), .out_index(outIndexC), .busy(busyC), .done(doneC)
   );

   // Register file and data memory models: one-cycle registered reads
   always @(posedge clk1) begin
      if (regRdA) regRdataA <= regFile[regAddrA];
      if (regRdB) regRdataB <= regFile[regAddrB];
      if (regRdC) regRdataC <= regFile[regAddrC];
      if (memRdA) memRdataA <= memA[memAddrA];
      if (memRdB) begin
         memRdataB <= memB[memAddrB];
         memAddrLogB.push_back(int'(memAddrB));
      end
      if (memRdC) begin
         memRdataC <= 32'hDEAD_BEEF;
         memRdCountC++;
      end
   end

   // Route the instance under test onto one set of observation signals
   always_comb begin
      curValid = outValidA; curData = outDataA; curTag = outTagA;
      curIndex = outIndexA; curBusy = busyA; curDone = doneA; curRegRd = regRdA;
      case (sel)
         1: begin
            curValid = outValidB; curData = outDataB; curTag = outTagB;
            curIndex = outIndexB; curBusy = busyB; curDone = doneB; curRegRd = regRdB;
         end
         2: begin
            curValid = outValidC; curData = outDataC; curTag = outTagC;
            curIndex = outIndexC; curBusy = busyC; curDone = doneC; curRegRd = regRdC;
         end
         default: ;
      endcase
   end

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
                  tag, actual, actual, expected, expected);
      end
   endtask

   function automatic logic [31:0] expectedWord(input int s, input int b);
      if (s == 1) return EXP_B[b];
      return EXP_A[b];
   endfunction

   task automatic clearStarts();
      startS[0] = 1'b0;
      startS[1] = 1'b0;
      startS[2] = 1'b0;
   endtask

   // Checks every outward-facing signal of instance A is in its reset value
   task automatic checkResetA(input string tag);
      checkOutput({tag, "_valid"}, 32'(outValidA), 32'd0);
      checkOutput({tag, "_busy"},  32'(busyA),     32'd0);
      checkOutput({tag, "_done"},  32'(doneA),     32'd0);
      checkOutput({tag, "_regRd"}, 32'(regRdA),    32'd0);
      checkOutput({tag, "_memRd"}, 32'(memRdA),    32'd0);
      checkOutput({tag, "_regAddr"}, 32'(regAddrA), 32'd0);
      checkOutput({tag, "_memAddr"}, 32'(memAddrA), 32'd0);
      checkOutput({tag, "_data"},  outDataA,       32'd0);
      checkOutput({tag, "_index"}, 32'(outIndexA), 32'd0);
      checkOutput({tag, "_tag"},   32'(outTagA),   32'd0);
   endtask

   // Triggers one dump on instance s at the current negedge and follows it
   // beat by beat. Optional: stall one beat, pulse start during one beat, or
   // assert reset during one beat (which abandons the dump).
   task automatic applyStimulus(input int s, input int trig, input int stallBeat,
                                input int startBeat, input int resetBeat);
      int nRegs;
      int nMem;
      int waited;
      int extra;
      sel   = s;
      nRegs = (s == 1) ? 1 : 6;
      nMem  = (s == 2) ? 0 : 2;
      if (trig == 0) haltedS[s] = 1'b1;
      else           startS[s]  = 1'b1;
      for (int b = 0; b < nRegs + nMem; b++) begin
         waited = 0;
         do begin
            @(negedge clk1);
            waited++;
            clearStarts();
            if (b == stallBeat) outReady = 1'b0;
            if (b == 0 && waited == 1) begin
               checkOutput("busyAfterTrigger", 32'(curBusy), 32'd1);
               checkOutput("doneClearedOnTrigger", 32'(curDone), 32'd0);
            end
         end while (!curValid && waited < 20);
         if (!curValid) begin
            checkOutput("beatTimeout", 32'(curValid), 32'd1);
            return;
         end
         checkOutput("beatLatency", 32'(waited), 32'd3);
         checkOutput("beatTag", 32'(curTag), (b >= nRegs) ? 32'd1 : 32'd0);
         checkOutput("beatIndex", 32'(curIndex), 32'((b >= nRegs) ? b - nRegs : b));
         checkOutput("beatData", curData, expectedWord(s, b));
         if (b == resetBeat) begin
            #2 reset = 1'b1;
            #1 checkResetA("midReset");
            @(negedge clk1);
            reset = 1'b0;
            return;
         end
         if (b == stallBeat) begin
            extra = 0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk1);
               checkOutput("stallValid", 32'(curValid), 32'd1);
               checkOutput("stallData", curData, expectedWord(s, b));
               checkOutput("stallIndex", 32'(curIndex), 32'(b));
               if (curRegRd) extra++;
            end
            checkOutput("stallNoReadStrobe", 32'(extra), 32'd0);
            outReady = 1'b1;
         end
         if (b == startBeat) startS[s] = 1'b1;
      end
      @(negedge clk1);
      clearStarts();
      checkOutput("doneAfterLastBeat", 32'(curDone), 32'd1);
      checkOutput("idleBusyAfterLastBeat", 32'(curBusy), 32'd0);
      checkOutput("validDropAfterLastBeat", 32'(curValid), 32'd0);
      extra = 0;
      repeat (6) begin
         @(negedge clk1);
         if (curValid) extra++;
      end
      checkOutput("noExtraBeats", 32'(extra), 32'd0);
      checkOutput("doneHeld", 32'(curDone), 32'd1);
   endtask

   initial begin
      int cnt;
      sel = 0;
      reset = 1'b1;
      outReady = 1'b1;
      memRdCountC = 0;
      for (int i = 0; i < 3; i++) begin
         haltedS[i] = 1'b0;
         startS[i]  = 1'b0;
      end
      for (int i = 0; i < 32; i++) regFile[i] = 32'd0;
      for (int i = 0; i < 1024; i++) memA[i] = 32'd0;
      for (int i = 0; i < 128; i++) memB[i] = 32'd0;
      regFile[1] = 32'd120; regFile[2] = 32'd85; regFile[3] = 32'd3;
      regFile[4] = 32'd4;   regFile[5] = 32'd130;
      memA[120] = 32'd85;   memA[121] = 32'd130;
      memB[127] = 32'h0000_00AA;
      memB[0]   = 32'h0000_00BB;

      // Asynchronous reset seen mid-cycle
      #3 checkResetA("powerOnReset");
      @(negedge clk1);
      @(negedge clk1);
      reset = 1'b0;
      repeat (2) @(negedge clk1);

      $display("[TB] normal dump on halted rising");
      applyStimulus(0, 0, -1, -1, -1);

      $display("[TB] start in DONE, backpressure on R2, start during R3");
      applyStimulus(0, 1, 2, 3, -1);

      $display("[TB] reset during R4");
      applyStimulus(0, 1, -1, -1, 4);
      cnt = 0;
      repeat (10) begin
         @(negedge clk1);
         if (outValidA || busyA) cnt++;
      end
      checkOutput("noDumpAfterResetWithHaltedHigh", 32'(cnt), 32'd0);

      $display("[TB] start after reset gives full dump");
      applyStimulus(0, 1, -1, -1, -1);

      haltedS[0] = 1'b0;
      @(negedge clk1);
      checkOutput("haltedFallInDoneClearsDone", 32'(doneA), 32'd0);
      checkOutput("haltedFallInDoneNotBusy", 32'(busyA), 32'd0);

      $display("[TB] NUM_REGS=1 with wrapping memory address");
      applyStimulus(1, 0, -1, -1, -1);
      checkOutput("wrapAddrCount", 32'(memAddrLogB.size()), 32'd2);
      if (memAddrLogB.size() == 2) begin
         checkOutput("wrapAddrFirst", 32'(memAddrLogB[0]), 32'd127);
         checkOutput("wrapAddrSecond", 32'(memAddrLogB[1]), 32'd0);
      end

      $display("[TB] MEM_COUNT=0");
      applyStimulus(2, 1, -1, -1, -1);
      checkOutput("noMemReadsWhenCountZero", 32'(memRdCountC), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/mips_state_dump.md
Name: mips_state_dump

Overview:
- Post-run readout engine for the pipe_MIPS32 core: the reader counterpart to the program/data loader that writes the core's memories before a run.
- Waits for the core to halt, or for an explicit start, then reads NUM_REGS general registers and MEM_COUNT data-memory words starting at MEM_BASE.
- Streams each word out on a valid/ready port, with a tag and index, to a bench monitor or host link.

Parameters:
NUM_REGS, 6, registers read, R0..R(NUM_REGS-1); legal range 1..32
MEM_AW, 10, data-memory address width
MEM_BASE, 120, first data-memory word address read
MEM_COUNT, 2, data-memory words read; 0 skips the memory phase

Ports:
clk1  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
halted  in  1  core HALTED flag
start  in  1  one-cycle request to run a dump; honoured only in IDLE or DONE
reg_addr  out  5  register-file read address
reg_rd  out  1  register read strobe
reg_rdata  in  32  register data, valid the cycle after reg_rd
mem_addr  out  MEM_AW  data-memory read address
mem_rd  out  1  memory read strobe
mem_rdata  in  32  memory data, valid the cycle after mem_rd
out_valid  out  1  stream beat valid
out_ready  in  1  sink accepts beat
out_data  out  32  word read
out_tag  out  1  0 = register, 1 = memory
out_index  out  8  register number, or memory offset from MEM_BASE
busy  out  1  sequence in progress
done  out  1  full dump delivered

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; index counter 0; halted_q 0. A partial dump is dropped and is not resumed.
- Trigger: halted & ~halted_q, using a registered copy of halted, or start. Either trigger in IDLE or DONE begins a dump.
- Triggers are ignored while busy.
- FSM states: IDLE, ISSUE, CAPTURE, SEND, DONE.
- IDLE -> ISSUE on trigger: clear done, set busy, idx=0, phase=REG.
- ISSUE, one cycle:
  - REG phase: reg_addr=idx, reg_rd=1.
  - MEM phase: mem_addr=(MEM_BASE+idx) truncated to MEM_AW bits (wraps modulo 2^MEM_AW), mem_rd=1.
  - The strobe is high only in ISSUE. Addresses hold their last value otherwise.
  - Next state: CAPTURE.
- CAPTURE, one cycle: latch the phase's rdata into out_data, out_tag=phase, out_index=idx; next state SEND.
- SEND:
  - out_valid=1; out_data, out_tag and out_index are held stable until out_valid & out_ready.
  - No combinational path from out_ready to any output.
  - On accept, out_valid drops the next cycle, then:
    - REG phase, idx<NUM_REGS-1: idx+1, go to ISSUE.
    - REG phase, idx=NUM_REGS-1: go to MEM phase with idx=0 if MEM_COUNT>0, else go to DONE.
    - MEM phase, idx<MEM_COUNT-1: idx+1, go to ISSUE.
    - MEM phase, last word: go to DONE.
- Latency: first out_valid 3 cycles after the trigger edge (IDLE->ISSUE->CAPTURE->SEND). With out_ready held high, one beat every 3 cycles.
- Total beats: NUM_REGS+MEM_COUNT, always in order R0..R(NUM_REGS-1), then M0..M(MEM_COUNT-1).
- DONE: done=1, busy=0.
  - Held until a new trigger, which restarts at ISSUE with done cleared that cycle.
  - halted falling in DONE -> IDLE, done cleared.
- halted falling mid-dump: ignored; the dump completes.
- Simultaneous start and halted rising edge: treated as one trigger.

Test Plan:
- Reset: assert reset mid-cycle -> immediately out_valid=0, busy=0, done=0, reg_rd=0, mem_rd=0, all addresses 0.
- Normal dump:
  - Stimulus: R0..R5={0,120,85,3,4,130}, Mem[120]=85, Mem[121]=130, out_ready=1; halted rises.
  - Required beats: (tag0,idx0,0) (0,1,120) (0,2,85) (0,3,3) (0,4,4) (0,5,130), then (1,0,85) (1,1,130).
  - First valid 3 cycles after the edge, 3 cycles per beat; done=1 after the 8th accept.
- Backpressure: out_ready low 5 cycles on beat R2 -> out_valid, data=85 and index held stable; no further reg_rd strobes until accepted; output sequence unchanged.
- Start while busy: pulse start during beat R3 -> ignored; exactly 8 beats delivered. Start in DONE -> done clears and a full 8-beat dump repeats.
- Reset mid-operation: reset during SEND of R4 -> outputs 0, state IDLE. With halted still high and no new edge, no dump occurs. A start then yields a complete dump from R0.
- Boundaries:
  - MEM_COUNT=0 -> 6 beats, then done.
  - MEM_AW=7, MEM_BASE=127, MEM_COUNT=2 -> mem_addr 127, then 0.
  - NUM_REGS=1 -> only R0 is read before the memory phase.
